// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling from an internal
// clocks-per-bit divider, valid/ready output with parity/framing/overrun flags.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 2,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q;
  logic                 parity_error_q;
  logic                 framing_error_q;
  logic                 overrun_q;

  logic rx_s;
  logic frame_done;
  logic ferr_d;
  logic perr_d;
  logic shift_par;

  assign rx_s      = sync_q[1];
  assign shift_par = ^shift_q;

  always_comb begin
    frame_done = (state_q == STOP) && (cnt_q == CNT_LAST) && (idx_q == STOP_LAST);
    ferr_d     = ferr_q | ~rx_s;
    perr_d     = (PARITY_MODE == 1) ? (rx_s ^ shift_par) : ~(rx_s ^ shift_par);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sync_q          <= 2'b11;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      perr_q          <= 1'b0;
      ferr_q          <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      overrun_q <= 1'b0;

      if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end

      // A frame completing while the previous word is still unaccepted is dropped.
      if (frame_done) begin
        if (!data_valid_q || data_ready) begin
          data_out_q      <= shift_q;
          parity_error_q  <= perr_q;
          framing_error_q <= ferr_d;
          data_valid_q    <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= '0;
              idx_q   <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == DATA_LAST) begin
              idx_q   <= '0;
              state_q <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            perr_q  <= perr_d;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            ferr_q <= ferr_d;
            if (idx_q == STOP_LAST) begin
              idx_q   <= '0;
              state_q <= rx_s ? IDLE : BREAK_WAIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        BREAK_WAIT: begin
          // Line held low past the frame: wait for idle before hunting for a start bit.
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun_error = overrun_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8/odd/1 instance plus a 5/none/2 instance.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [7:0] dout_a;
  logic [4:0] dout_b;
  logic       dv_a, pe_a, fe_a, ov_a, busy_a;
  logic       dv_b, pe_b, fe_b, ov_b, busy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_param dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a),
    .data_out(dout_a), .data_valid(dv_a), .data_ready(ready_a),
    .parity_error(pe_a), .framing_error(fe_a), .overrun_error(ov_a), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b),
    .data_out(dout_b), .data_valid(dv_b), .data_ready(ready_b),
    .parity_error(pe_b), .framing_error(fe_b), .overrun_error(ov_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame, 16 cycles per bit, starting at posedge+1. lat is the
  // cycle count (from the rx pin going low) at which data_valid first rises.
  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input int pmode, input bit flip, input int nstop,
                            input logic [1:0] stop_vals, output int lat, output int ovs);
    logic [15:0] bits;
    int   n, cyc;
    logic ones, p, prev, dvnow;
    bits = '0;
    n    = 1;
    ones = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = data[i];
      ones    = ones ^ data[i];
      n++;
    end
    if (pmode != 0) begin
      p = (pmode == 1) ? ones : ~ones;
      bits[n] = p ^ flip;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[n] = stop_vals[s];
      n++;
    end
    lat  = -1;
    ovs  = 0;
    cyc  = 0;
    prev = sel ? dv_b : dv_a;
    for (int b = 0; b < n; b++) begin
      if (sel) rx_b = bits[b]; else rx_a = bits[b];
      repeat (16) begin
        @(posedge clk); #1;
        cyc++;
        dvnow = sel ? dv_b : dv_a;
        if (dvnow && !prev && lat < 0) lat = cyc;
        prev = dvnow;
        if (sel ? ov_b : ov_a) ovs++;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         stop_low;
    logic [7:0] exp_data;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[5];
  int   lat, ovs;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dv_a", dv_a, 0);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_dout_a", dout_a, 0);
    chk("reset_flags_a", {pe_a, fe_a, ov_a}, 0);
    chk("reset_dv_b", dv_b, 0);
    chk("reset_busy_b", busy_b, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8 data + parity + 1 stop: 2 sync cycles + 169 cycles from the rx_s fall.
    for (int v = 0; v < 5; v++) begin
      send_frame(1'b0, {1'b0, vecs[v].data}, 8, 2, vecs[v].flip_par, 1,
                 vecs[v].stop_low ? 2'b00 : 2'b11, lat, ovs);
      $display("vec %0d: data=%02h pe=%0b fe=%0b lat=%0d", v, dout_a, pe_a, fe_a, lat);
      chk("vec_dv", dv_a, 1);
      chk("vec_data", dout_a, vecs[v].exp_data);
      chk("vec_pe", pe_a, vecs[v].exp_pe);
      chk("vec_fe", fe_a, vecs[v].exp_fe);
      chk("vec_latency", lat, 171);
      chk("vec_no_overrun", ovs, 0);
      if (vecs[v].stop_low) begin
        repeat (30) @(posedge clk);
        #1;
        chk("break_wait_busy", busy_a, 1);
        rx_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("break_exit_busy", busy_a, 0);
      end
      ready_a = 1'b1;
      @(posedge clk); #1;
      ready_a = 1'b0;
      chk("vec_accept_dv", dv_a, 0);
      repeat (4) @(posedge clk);
      #1;
    end

    // False start: 5-cycle low pulse.
    rx_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("false_start_busy_hi", busy_a, 1);
    rx_a = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    $display("false start: busy=%0b dv=%0b", busy_a, dv_a);
    chk("false_start_busy_lo", busy_a, 0);
    chk("false_start_dv", dv_a, 0);

    // Back-to-back frames with no acceptance: second one is dropped.
    send_frame(1'b0, 9'h011, 8, 2, 1'b0, 1, 2'b11, lat, ovs);
    chk("ovr_first_ovs", ovs, 0);
    chk("ovr_first_data", dout_a, 8'h11);
    send_frame(1'b0, 9'h022, 8, 2, 1'b0, 1, 2'b11, lat, ovs);
    $display("overrun: data=%02h dv=%0b pulses=%0d", dout_a, dv_a, ovs);
    chk("ovr_pulse_count", ovs, 1);
    chk("ovr_data_kept", dout_a, 8'h11);
    chk("ovr_dv_held", dv_a, 1);
    ready_a = 1'b1;
    @(posedge clk); #1;
    ready_a = 1'b0;
    chk("ovr_accept_dv", dv_a, 0);
    repeat (4) @(posedge clk);
    #1;

    // 5 data bits, no parity, 2 stop: 2 + (7.5*16 + 1) cycles.
    send_frame(1'b1, 9'h01F, 5, 0, 1'b0, 2, 2'b11, lat, ovs);
    $display("b 1F: data=%02h fe=%0b lat=%0d", dout_b, fe_b, lat);
    chk("b_dv", dv_b, 1);
    chk("b_data", dout_b, 5'h1F);
    chk("b_fe", fe_b, 0);
    chk("b_pe", pe_b, 0);
    chk("b_latency", lat, 123);
    ready_b = 1'b1;
    @(posedge clk); #1;
    ready_b = 1'b0;
    send_frame(1'b1, 9'h00A, 5, 0, 1'b0, 2, 2'b01, lat, ovs);
    $display("b 0A stop2 low: data=%02h fe=%0b", dout_b, fe_b);
    chk("b2_data", dout_b, 5'h0A);
    chk("b2_fe", fe_b, 1);
    rx_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("b2_busy_idle", busy_b, 0);

    // Reset in the middle of the data bits.
    rx_a = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", busy_a, 1);
    rst_n = 1'b0;
    #1;
    $display("mid-frame reset: dv=%0b busy=%0b data=%02h", dv_a, busy_a, dout_a);
    chk("rst_async_busy", busy_a, 0);
    chk("rst_async_dout", dout_a, 0);
    chk("rst_async_dv", dv_a, 0);
    chk("rst_async_dv_b", dv_b, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_dv", dv_a, 0);
    chk("post_rst_busy", busy_a, 0);
    send_frame(1'b0, 9'h05A, 8, 2, 1'b0, 1, 2'b11, lat, ovs);
    $display("after reset 5A: data=%02h pe=%0b fe=%0b lat=%0d", dout_a, pe_a, fe_a, lat);
    chk("post_rst_data", dout_a, 8'h5A);
    chk("post_rst_flags", {pe_a, fe_a}, 0);
    chk("post_rst_latency", lat, 171);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
